i2s_receiver: RTL and testbench

Serial-to-parallel receiver for the audio link: oversamples an external I²S-style stream (bit clock, word select, data) with the system clock, deserialises 16-bit left/right words and delivers complete stereo frames over a valid/ready interface. It is the far end of the audio system's I²S transmitter (`audio_bclk`/`audio_lrclk`/`audio_dout`). It is used for loopback verification of the audio path and as the audio-input path into the CPU/memory side.

---
 rtl/i2s_receiver.sv | 194 +++++++++++++++++++
 tb/tb_i2s_receiver.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_receiver.sv
`default_nettype none
// ============================================================================
// Module      : i2s_receiver
// Description : Oversampling I2S receiver; deserialises left-justified
//               left/right words and delivers stereo frames over valid/ready.
//               Optional frame FIFO enabled by defining I2S_RX_FIFO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_receiver #(
    parameter int WORD_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i2s_bclk,
    input  logic                  i2s_lrclk,
    input  logic                  i2s_din,
    output logic [WORD_WIDTH-1:0] o_left,
    output logic [WORD_WIDTH-1:0] o_right,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_synced,
    output logic                  o_frame_error,
    output logic                  o_overrun,
    input  logic                  i_clear_overrun
);

    localparam int                 c_CNT_W    = $clog2(WORD_WIDTH + 2);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(WORD_WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT  = c_CNT_W'(WORD_WIDTH + 1);

    typedef enum logic [0:0] {
        ST_SYNC    = 1'b0,
        ST_RECEIVE = 1'b1
    } state_t;

    state_t                r_state;
    logic                  r_bclk_meta, r_bclk_sync, r_bclk_dly;
    logic                  r_lr_meta, r_lr_sync;
    logic                  r_din_meta, r_din_sync;
    logic                  r_prev_lr;
    logic                  r_ws_seen;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [WORD_WIDTH-1:0] r_shift;
    logic [WORD_WIDTH-1:0] r_left_hold;
    logic                  r_left_valid;

    logic w_rise;
    logic w_ws_change;
    logic w_word_ok;
    logic w_push;
    logic w_pop;
    logic w_accept;

    assign w_rise      = r_bclk_sync & ~r_bclk_dly;
    assign w_ws_change = r_lr_sync ^ r_prev_lr;
    assign w_word_ok   = (r_cnt == c_CNT_FULL);
    // A frame is complete when a full right word ends while a left word waits.
    assign w_push      = w_rise && (r_state == ST_RECEIVE) && w_ws_change &&
                         w_word_ok && r_prev_lr && r_left_valid;
    assign w_pop       = o_valid & i_ready;
    assign o_synced    = (r_state == ST_RECEIVE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bclk_meta   <= 1'b0;
            r_bclk_sync   <= 1'b0;
            r_bclk_dly    <= 1'b0;
            r_lr_meta     <= 1'b0;
            r_lr_sync     <= 1'b0;
            r_din_meta    <= 1'b0;
            r_din_sync    <= 1'b0;
            r_state       <= ST_SYNC;
            r_prev_lr     <= 1'b0;
            r_ws_seen     <= 1'b0;
            r_cnt         <= '0;
            r_shift       <= '0;
            r_left_hold   <= '0;
            r_left_valid  <= 1'b0;
            o_frame_error <= 1'b0;
        end else begin
            r_bclk_meta   <= i2s_bclk;
            r_bclk_sync   <= r_bclk_meta;
            r_bclk_dly    <= r_bclk_sync;
            r_lr_meta     <= i2s_lrclk;
            r_lr_sync     <= r_lr_meta;
            r_din_meta    <= i2s_din;
            r_din_sync    <= r_din_meta;
            o_frame_error <= 1'b0;
            if (w_rise) begin
                r_prev_lr <= r_lr_sync;
                r_ws_seen <= 1'b1;
                case (r_state)
                    ST_SYNC: begin
                        // The first sample after reset only establishes a reference.
                        if (r_ws_seen && w_ws_change) begin
                            r_state <= ST_RECEIVE;
                            r_shift <= {{(WORD_WIDTH-1){1'b0}}, r_din_sync};
                            r_cnt   <= c_CNT_ONE;
                        end
                    end
                    ST_RECEIVE: begin
                        if (w_ws_change) begin
                            if (!w_word_ok) begin
                                o_frame_error <= 1'b1;
                                r_left_valid  <= 1'b0;
                            end else if (!r_prev_lr) begin
                                r_left_hold  <= r_shift;
                                r_left_valid <= 1'b1;
                            end else begin
                                r_left_valid <= 1'b0;
                            end
                            r_shift <= {{(WORD_WIDTH-1){1'b0}}, r_din_sync};
                            r_cnt   <= c_CNT_ONE;
                        end else begin
                            if (r_cnt < c_CNT_FULL)
                                r_shift <= {r_shift[WORD_WIDTH-2:0], r_din_sync};
                            if (r_cnt < c_CNT_SAT)
                                r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                    default: r_state <= ST_SYNC;
                endcase
            end
        end
    end

`ifdef I2S_RX_FIFO_EN
    localparam int c_AW = $clog2(FIFO_DEPTH);

    logic [WORD_WIDTH-1:0] r_mem_left  [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0] r_mem_right [FIFO_DEPTH];
    logic [c_AW:0]         r_wr_ptr;
    logic [c_AW:0]         r_rd_ptr;
    logic                  w_empty;
    logic                  w_full;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_accept = w_push && (!w_full || w_pop);
    assign o_valid  = ~w_empty;
    assign o_left   = r_mem_left[r_rd_ptr[c_AW-1:0]];
    assign o_right  = r_mem_right[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_left[i]  <= '0;
                r_mem_right[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_mem_left[r_wr_ptr[c_AW-1:0]]  <= r_left_hold;
                r_mem_right[r_wr_ptr[c_AW-1:0]] <= r_shift;
                r_wr_ptr                        <= r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end
`else
    assign w_accept = w_push && (!o_valid || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_left  <= '0;
            o_right <= '0;
            o_valid <= 1'b0;
        end else if (w_accept) begin
            o_left  <= r_left_hold;
            o_right <= r_shift;
            o_valid <= 1'b1;
        end else if (w_pop) begin
            o_valid <= 1'b0;
        end
    end
`endif

    // A dropped frame in the same cycle as a clear request keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            o_overrun <= 1'b0;
        else if (w_push && !w_accept)
            o_overrun <= 1'b1;
        else if (i_clear_overrun)
            o_overrun <= 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_receiver
// Description : Self-checking bench for i2s_receiver with a slot-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_receiver;

    localparam int W     = 16;
    localparam int DEPTH = 4;
`ifdef I2S_RX_FIFO_EN
    localparam int BP_FRAMES = 5;
    localparam int BP_CAP    = DEPTH;
`else
    localparam int BP_FRAMES = 2;
    localparam int BP_CAP    = 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         bclk = 1'b0;
    logic         lrclk = 1'b0;
    logic         din = 1'b0;
    logic         ready = 1'b1;
    logic         clr = 1'b0;
    logic [W-1:0] o_left, o_right;
    logic         o_valid, o_synced, o_frame_error, o_overrun;

    always #5 clk = ~clk;

    i2s_receiver #(.WORD_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .i2s_bclk        (bclk),
        .i2s_lrclk       (lrclk),
        .i2s_din         (din),
        .o_left          (o_left),
        .o_right         (o_right),
        .o_valid         (o_valid),
        .i_ready         (ready),
        .o_synced        (o_synced),
        .o_frame_error   (o_frame_error),
        .o_overrun       (o_overrun),
        .i_clear_overrun (clr)
    );

    int          total = 0;
    int          bad = 0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    int          exp_err = 0;
    int          err_pulses = 0;
    int          err_run = 0;
    int          err_max = 0;
    int          unstable = 0;
    logic        hold_prev = 1'b0;
    logic [31:0] val_prev = '0;

    // Slot-level reference: a slot is evaluated when the next slot begins.
    bit          m_have_prev = 0;
    bit          m_prev_lr = 0;
    bit          m_prev_aligned = 0;
    bit          m_pending = 0;
    int          m_prev_len = 0;
    logic [15:0] m_prev_data = '0;
    logic [15:0] m_pl = '0;

    always @(negedge clk) begin
        if (o_valid && ready)
            got_q.push_back({o_left, o_right});
        if (o_frame_error) begin
            err_run <= err_run + 1;
            if (err_run == 0)
                err_pulses <= err_pulses + 1;
            if (err_run + 1 > err_max)
                err_max <= err_run + 1;
        end else begin
            err_run <= 0;
        end
        if (hold_prev && o_valid && ({o_left, o_right} !== val_prev))
            unstable <= unstable + 1;
        hold_prev <= o_valid && !ready;
        val_prev  <= {o_left, o_right};
    end

    task automatic model_slot(input bit lr, input logic [15:0] data, input int len);
        bit aligned;
        aligned = m_have_prev && (lr != m_prev_lr);
        if (aligned && m_prev_aligned) begin
            if (m_prev_len != W) begin
                exp_err++;
                m_pending = 0;
            end else if (!m_prev_lr) begin
                m_pending = 1;
                m_pl      = m_prev_data;
            end else if (m_pending) begin
                exp_q.push_back({m_pl, m_prev_data});
                m_pending = 0;
            end
        end
        m_have_prev    = 1;
        m_prev_lr      = lr;
        m_prev_aligned = aligned;
        m_prev_len     = len;
        m_prev_data    = data;
    endtask

    task automatic model_reset();
        m_have_prev = 0;
        m_pending   = 0;
    endtask

    // One bclk period; data and word select change with the falling edge.
    task automatic send_bit(input bit lr, input bit b, input bit pulse_ready);
        lrclk = lr;
        din   = b;
        repeat (12) @(negedge clk);
        bclk = 1'b1;
        if (pulse_ready) begin
            @(posedge clk);
            @(posedge clk);
            #1 ready = 1'b1;
            @(posedge clk);
            #1 ready = 1'b0;
            repeat (10) @(negedge clk);
        end else begin
            repeat (12) @(negedge clk);
        end
        bclk = 1'b0;
    endtask

    task automatic send_slot(input bit lr, input logic [15:0] data, input int len);
        model_slot(lr, data, len);
        for (int i = len - 1; i >= 0; i--)
            send_bit(lr, data[i], 1'b0);
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_slot(1'b0, l, W);
        send_slot(1'b1, r, W);
    endtask

    task automatic settle();
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        repeat (3) @(posedge clk);
        #1;
        total++; if (o_left !== '0)        begin bad++; $display("FAIL reset_left: got %h want 0", o_left); end
        total++; if (o_right !== '0)       begin bad++; $display("FAIL reset_right: got %h want 0", o_right); end
        total++; if (o_valid !== 1'b0)     begin bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        total++; if (o_synced !== 1'b0)    begin bad++; $display("FAIL reset_synced: got %b want 0", o_synced); end
        total++; if (o_frame_error !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", o_frame_error); end
        total++; if (o_overrun !== 1'b0)   begin bad++; $display("FAIL reset_overrun: got %b want 0", o_overrun); end
        d = 16'($urandom);
        for (int i = 15; i >= 11; i--)
            send_bit(1'b1, d[i], 1'b0);
        rst = 1'b0;
        model_slot(1'b1, d, 11);
        for (int i = 10; i >= 0; i--)
            send_bit(1'b1, d[i], 1'b0);
        total++; if (o_synced !== 1'b0) begin bad++; $display("FAIL sync_before_change: got %b want 0", o_synced); end
    endtask

    task automatic test_sync_start();
        logic [31:0] g, e;
        for (int f = 1; f <= 3; f++)
            send_frame(16'(f), 16'(16'h8000 + f));
        send_frame(16'($urandom), 16'($urandom));
        settle();
        total++; if (got_q.size() != 3) begin bad++; $display("FAIL sync_count: got %0d frames want 3", got_q.size()); end
        total++; if (err_pulses != exp_err) begin bad++; $display("FAIL sync_errors: got %0d want %0d", err_pulses, exp_err); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL sync_frames: got %0d want %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL sync_frame: got %h want %h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_basic();
        logic [31:0] g, e;
        send_frame(16'h1234, 16'hABCD);
        total++; if (o_synced !== 1'b1) begin bad++; $display("FAIL basic_synced: got %b want 1", o_synced); end
        send_frame(16'($urandom), 16'($urandom));
        settle();
        total++; if (got_q.size() < 2 || got_q[1] !== 32'h1234ABCD) begin bad++; $display("FAIL basic_value: got %0d frames, want 1234abcd second", got_q.size()); end
        total++; if (err_pulses != exp_err) begin bad++; $display("FAIL basic_errors: got %0d want %0d", err_pulses, exp_err); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL basic_frames: got %0d want %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL basic_frame: got %h want %h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_short_slot();
        logic [31:0] g, e;
        int          e0;
        e0 = err_pulses;
        send_slot(1'b0, 16'($urandom), 15);
        send_slot(1'b1, 16'($urandom), 16);
        send_frame(16'h5555, 16'hAAAA);
        send_frame(16'($urandom), 16'($urandom));
        settle();
        total++; if (err_pulses - e0 != 1) begin bad++; $display("FAIL short_pulses: got %0d want 1", err_pulses - e0); end
        total++; if (err_max != 1) begin bad++; $display("FAIL short_width: got %0d cycles want 1", err_max); end
        total++; if (err_pulses != exp_err) begin bad++; $display("FAIL short_errors: got %0d want %0d", err_pulses, exp_err); end
        total++; if (got_q.size() < 2 || got_q[1] !== 32'h5555AAAA) begin bad++; $display("FAIL short_value: got %0d frames, want 5555aaaa second", got_q.size()); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL short_frames: got %0d want %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL short_frame: got %h want %h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        logic [31:0] g, e;
        int          n;
        n = $urandom_range(3, 6);
        for (int f = 0; f < n; f++)
            send_frame(16'($urandom), 16'($urandom));
        settle();
        total++; if (err_pulses != exp_err) begin bad++; $display("FAIL random_errors: got %0d want %0d", err_pulses, exp_err); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL random_frames: got %0d want %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL random_frame: got %h want %h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic [31:0] g, e, head;
        int          e0;
        settle();
        ready = 1'b0;
        e0 = exp_q.size();
        for (int f = 0; f < BP_FRAMES; f++)
            send_frame(16'($urandom), 16'($urandom));
        settle();
        while (exp_q.size() > e0 + BP_CAP)
            void'(exp_q.pop_back());
        head = (exp_q.size() > e0) ? exp_q[e0] : 32'hxxxxxxxx;
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", o_valid); end
        total++; if ({o_left, o_right} !== head) begin bad++; $display("FAIL bp_head: got %h want %h", {o_left, o_right}, head); end
        total++; if (o_overrun !== 1'b1) begin bad++; $display("FAIL bp_overrun: got %b want 1", o_overrun); end
        total++; if (unstable != 0) begin bad++; $display("FAIL bp_stable: got %0d changes want 0", unstable); end
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        total++; if (o_overrun !== 1'b0) begin bad++; $display("FAIL bp_clear: got %b want 0", o_overrun); end
        ready = 1'b1;
        settle();
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_frames: got %0d want %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL bp_frame: got %h want %h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_simultaneous();
        logic [31:0] g, e, d_exp;
        logic [15:0] al, ar, bl;
        al = 16'($urandom); ar = 16'($urandom); bl = 16'($urandom);
        settle();
        ready = 1'b0;
        send_slot(1'b0, al, W);
        send_slot(1'b1, ar, W);
        model_slot(1'b0, bl, W);
        send_bit(1'b0, bl[15], 1'b1);
        settle();
        d_exp = (exp_q.size() > 0) ? exp_q[0] : 32'hxxxxxxxx;
        total++; if (got_q.size() != 1 || got_q[0] !== d_exp) begin bad++; $display("FAIL simul_pop: got %0d popped want 1 of %h", got_q.size(), d_exp); end
        total++; if (o_valid !== 1'b1 || {o_left, o_right} !== {al, ar}) begin bad++; $display("FAIL simul_load: got v=%b %h want v=1 %h", o_valid, {o_left, o_right}, {al, ar}); end
        total++; if (o_overrun !== 1'b0) begin bad++; $display("FAIL simul_overrun: got %b want 0", o_overrun); end
        for (int i = 14; i >= 0; i--)
            send_bit(1'b0, bl[i], 1'b0);
        send_slot(1'b1, 16'($urandom), W);
        ready = 1'b1;
        settle();
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL simul_frames: got %0d want %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL simul_frame: got %h want %h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_async_reset();
        logic [31:0] g, e;
        logic [15:0] d;
        d = 16'($urandom);
        model_slot(1'b0, d, W);
        for (int i = 15; i >= 9; i--)
            send_bit(1'b0, d[i], 1'b0);
        rst = 1'b1;
        #1;
        total++; if ({o_left, o_right} !== 32'h0) begin bad++; $display("FAIL areset_data: got %h want 0", {o_left, o_right}); end
        total++; if (o_valid !== 1'b0 || o_synced !== 1'b0) begin bad++; $display("FAIL areset_flags: got v=%b s=%b want 0 0", o_valid, o_synced); end
        total++; if (o_overrun !== 1'b0 || o_frame_error !== 1'b0) begin bad++; $display("FAIL areset_status: got ovr=%b ferr=%b want 0 0", o_overrun, o_frame_error); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        model_slot(1'b0, d, 9);
        for (int i = 8; i >= 0; i--)
            send_bit(1'b0, d[i], 1'b0);
        total++; if (o_synced !== 1'b0) begin bad++; $display("FAIL areset_nosync: got %b want 0", o_synced); end
        send_slot(1'b1, 16'($urandom), W);
        total++; if (o_synced !== 1'b1) begin bad++; $display("FAIL areset_resync: got %b want 1", o_synced); end
        send_frame(16'($urandom), 16'($urandom));
        send_frame(16'($urandom), 16'($urandom));
        send_slot(1'b0, 16'($urandom), W);
        settle();
        total++; if (err_pulses != exp_err) begin bad++; $display("FAIL areset_errors: got %0d want %0d", err_pulses, exp_err); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL areset_frames: got %0d want %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL areset_frame: got %h want %h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sync_start();
        test_basic();
        test_short_slot();
        test_random();
        test_backpressure();
        test_simultaneous();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
